// File: rtl/grain_prog_ctrl_pkg.sv
// grain_prog_pkg: shared FSM states and CRC-8 helpers for the GrainFlex programming controller
package grain_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TRAILER,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ (((c[7] ^ b) != 1'b0) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/grain_prog_ctrl_if.sv
// grain_prog_ctrl_if: prog pin and config chain bundle between host pins, controller and fabric
interface grain_prog_ctrl_if #(
    parameter int CHAINS    = 1,
    parameter int CHAIN_LEN = 64
);
    logic                               prog_clk;
    logic                               prog_rst;
    logic                               prog_en;
    logic [CHAINS-1:0]                  prog_din;
    logic [CHAINS-1:0]                  prog_dout;
    logic                               cfg_shift_en;
    logic [CHAINS-1:0]                  cfg_data_out;
    logic [CHAINS-1:0]                  cfg_data_in;
    logic                               fabric_reset;
    logic                               cfg_done;
    logic                               cfg_error;
    logic [$clog2(CHAIN_LEN+9)-1:0]     bit_count;

    modport master (
        output prog_clk, prog_rst, prog_en, prog_din, cfg_data_in,
        input  prog_dout, cfg_shift_en, cfg_data_out, fabric_reset, cfg_done, cfg_error, bit_count
    );

    modport slave (
        input  prog_clk, prog_rst, prog_en, prog_din, cfg_data_in,
        output prog_dout, cfg_shift_en, cfg_data_out, fabric_reset, cfg_done, cfg_error, bit_count
    );

endinterface

// File: rtl/grain_prog_ctrl_sync_edge.sv
// grain_sync_edge: multi-stage synchroniser bank with rising-edge detect on bit 0
module grain_sync_edge #(
    parameter int W = 4,
    parameter int S = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         rise
);
    logic [W-1:0] st [S];
    logic         prev;

    // Every bit walks the same S stages, so data stays aligned with the detected edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < S; i++) st[i] <= '0;
            prev <= 1'b0;
        end else begin
            st[0] <= d;
            for (int i = 1; i < S; i++) st[i] <= st[i-1];
            prev <= st[S-1][0];
        end
    end

    assign q    = st[S-1];
    assign rise = st[S-1][0] & ~prev;

endmodule

// File: rtl/grain_prog_ctrl.sv
// grain_prog_ctrl: synchronises prog pins, shifts config chains, counts bits and checks the CRC-8 trailer
module grain_prog_ctrl
    import grain_prog_pkg::*;
#(
    parameter int CHAINS      = 1,
    parameter int CHAIN_LEN   = 64,
    parameter int SYNC_STAGES = 2,
    parameter int CRC_EN      = 1
) (
    input logic              clk,
    input logic              reset,
    grain_prog_ctrl_if.slave bus
);
    localparam int W  = CHAINS + 3;
    localparam int BW = $clog2(CHAIN_LEN + 9);
    localparam logic [BW-1:0] LOAD_LAST = BW'(CHAIN_LEN - 1);
    localparam logic [BW-1:0] TRL_LAST  = BW'(CHAIN_LEN + 7);

    logic [W-1:0]      sq;
    logic              rise;
    logic [CHAINS-1:0] din_s;
    logic              en_s, rst_s, acc;

    state_t            state, state_n;
    logic [BW-1:0]     cnt, cnt_n, cnt_inc;
    logic [7:0]        crc, crc_n, crc_upd, trl, trl_n, trl_sh;
    logic              shift, shift_n;
    logic [CHAINS-1:0] dout, dout_n, rb;

    grain_sync_edge #(.W(W), .S(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (reset),
        .d    ({bus.prog_din, bus.prog_en, bus.prog_rst, bus.prog_clk}),
        .q    (sq),
        .rise (rise)
    );

    assign din_s   = sq[W-1:3];
    assign en_s    = sq[2];
    assign rst_s   = sq[1];
    assign acc     = rise & sq[0] & en_s;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign trl_sh  = {trl[6:0], din_s[0]};

    // CRC absorbs chain 0 first, then the higher chains, all in one edge
    always_comb begin
        crc_upd = crc;
        for (int i = 0; i < CHAINS; i++) crc_upd = crc8_step(crc_upd, din_s[i]);
    end

    // Next-state logic: prog_rst wins over any coincident edge
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        crc_n   = crc;
        trl_n   = trl;
        shift_n = 1'b0;
        dout_n  = dout;
        if (rst_s) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            crc_n   = CRC8_INIT;
            trl_n   = '0;
        end else if (acc) begin
            unique case (state)
                ST_IDLE, ST_LOAD: begin
                    shift_n = 1'b1;
                    dout_n  = din_s;
                    crc_n   = crc_upd;
                    cnt_n   = (state == ST_IDLE) ? BW'(1) : cnt_inc;
                    state_n = (cnt == LOAD_LAST && state == ST_LOAD)
                              ? ((CRC_EN != 0) ? ST_TRAILER : ST_RUN) : ST_LOAD;
                end
                ST_TRAILER: begin
                    trl_n   = trl_sh;
                    cnt_n   = cnt_inc;
                    state_n = (cnt != TRL_LAST) ? ST_TRAILER : (trl_sh == crc) ? ST_RUN : ST_ERROR;
                end
                default: ;
            endcase
        end
    end

    // State and output registers; readback sampled every cycle regardless of state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            crc   <= CRC8_INIT;
            trl   <= '0;
            shift <= 1'b0;
            dout  <= '0;
            rb    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            crc   <= crc_n;
            trl   <= trl_n;
            shift <= shift_n;
            dout  <= dout_n;
            rb    <= bus.cfg_data_in;
        end
    end

    assign bus.cfg_shift_en = shift;
    assign bus.cfg_data_out = dout;
    assign bus.prog_dout    = rb;
    assign bus.bit_count    = cnt;
    assign bus.cfg_done     = (state == ST_RUN);
    assign bus.cfg_error    = (state == ST_ERROR);
    assign bus.fabric_reset = (state != ST_RUN);

endmodule

// File: tb/tb_grain_prog_ctrl.sv
// tb_grain_prog_ctrl: directed tests for the GrainFlex programming controller
module tb_grain_prog_ctrl;

    logic        clk;
    logic        reset;
    logic        pclk, prst;
    logic [2:0]  en;
    logic [1:0]  din;
    logic [1:0]  tail;
    int          n_chk, n_fail;
    int          sc0, sc1, sc2;
    logic [63:0] cap0;

    localparam logic [63:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;

    grain_prog_ctrl_if #(.CHAINS(1), .CHAIN_LEN(64)) bus0 ();
    grain_prog_ctrl_if #(.CHAINS(2), .CHAIN_LEN(64)) bus1 ();
    grain_prog_ctrl_if #(.CHAINS(1), .CHAIN_LEN(64)) bus2 ();

    assign bus0.prog_clk = pclk;  assign bus0.prog_rst = prst;  assign bus0.prog_en = en[0];
    assign bus0.prog_din = din[0]; assign bus0.cfg_data_in = tail[0];
    assign bus1.prog_clk = pclk;  assign bus1.prog_rst = prst;  assign bus1.prog_en = en[1];
    assign bus1.prog_din = din;    assign bus1.cfg_data_in = tail;
    assign bus2.prog_clk = pclk;  assign bus2.prog_rst = prst;  assign bus2.prog_en = en[2];
    assign bus2.prog_din = din[0]; assign bus2.cfg_data_in = tail[0];

    grain_prog_ctrl #(.CHAINS(1), .CHAIN_LEN(64), .SYNC_STAGES(2), .CRC_EN(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    grain_prog_ctrl #(.CHAINS(2), .CHAIN_LEN(64), .SYNC_STAGES(2), .CRC_EN(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    grain_prog_ctrl #(.CHAINS(1), .CHAIN_LEN(64), .SYNC_STAGES(3), .CRC_EN(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-strobe monitors: pulse counts and the bit stream seen by chain 0 of dut0
    always @(posedge clk) begin
        if (bus0.cfg_shift_en) begin
            sc0  <= sc0 + 1;
            cap0 <= {cap0[62:0], bus0.cfg_data_out[0]};
        end
        if (bus1.cfg_shift_en) sc1 <= sc1 + 1;
        if (bus2.cfg_shift_en) sc2 <= sc2 + 1;
    end

    function automatic logic [7:0] crc_ref(input logic [63:0] data);
        logic [7:0] c = 8'h00;
        for (int b = 0; b < 8; b++) begin
            c ^= data[63-8*b -: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] d, input logic [2:0] e);
        din = d;
        en  = e;
        cyc(2);
        pclk = 1'b1;
        cyc(5);
        pclk = 1'b0;
        cyc(5);
    endtask

    task automatic pulse_prog_rst;
        prst = 1'b1;
        cyc(6);
        prst = 1'b0;
        cyc(6);
    endtask

    task automatic load0(input logic [63:0] data, input logic [7:0] t);
        for (int i = 0; i < 64; i++) send({1'b0, data[63-i]}, 3'b001);
        for (int k = 0; k < 8; k++) send({1'b0, t[7-k]}, 3'b001);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(3);
        n_chk++; if (bus0.fabric_reset !== 1'b1) begin n_fail++; $display("FAIL reset_fabric_reset got %b exp 1", bus0.fabric_reset); end
        n_chk++; if (bus0.cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus0.cfg_done); end
        n_chk++; if (bus0.cfg_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b exp 0", bus0.cfg_error); end
        n_chk++; if (bus0.bit_count !== 7'd0) begin n_fail++; $display("FAIL reset_bit_count got %0d exp 0", bus0.bit_count); end
        n_chk++; if (bus0.cfg_shift_en !== 1'b0) begin n_fail++; $display("FAIL reset_shift_en got %b exp 0", bus0.cfg_shift_en); end
        n_chk++; if (bus1.cfg_data_out !== 2'b00) begin n_fail++; $display("FAIL reset_data_out got %b exp 00", bus1.cfg_data_out); end
        n_chk++; if (bus1.prog_dout !== 2'b00) begin n_fail++; $display("FAIL reset_prog_dout got %b exp 00", bus1.prog_dout); end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_good_load;
        int s;
        pulse_prog_rst();
        s = sc0;
        load0(PAT, crc_ref(PAT));
        n_chk++; if (sc0 - s !== 64) begin n_fail++; $display("FAIL good_shift_count got %0d exp 64", sc0 - s); end
        n_chk++; if (cap0 !== PAT) begin n_fail++; $display("FAIL good_chain_data got %h exp %h", cap0, PAT); end
        n_chk++; if (bus0.cfg_done !== 1'b1) begin n_fail++; $display("FAIL good_done got %b exp 1", bus0.cfg_done); end
        n_chk++; if (bus0.fabric_reset !== 1'b0) begin n_fail++; $display("FAIL good_fabric_reset got %b exp 0", bus0.fabric_reset); end
        n_chk++; if (bus0.cfg_error !== 1'b0) begin n_fail++; $display("FAIL good_error got %b exp 0", bus0.cfg_error); end
        n_chk++; if (bus0.bit_count !== 7'd72) begin n_fail++; $display("FAIL good_bit_count got %0d exp 72", bus0.bit_count); end
        s = sc0;
        send(2'b01, 3'b001);
        n_chk++; if (sc0 !== s) begin n_fail++; $display("FAIL run_locked got %0d shifts exp 0", sc0 - s); end
        n_chk++; if (bus0.bit_count !== 7'd72) begin n_fail++; $display("FAIL run_bit_count got %0d exp 72", bus0.bit_count); end
    endtask

    task automatic test_bad_crc;
        int s;
        pulse_prog_rst();
        n_chk++; if (bus0.fabric_reset !== 1'b1) begin n_fail++; $display("FAIL prst_fabric_reset got %b exp 1", bus0.fabric_reset); end
        load0(PAT, crc_ref(PAT) ^ 8'h01);
        n_chk++; if (bus0.cfg_error !== 1'b1) begin n_fail++; $display("FAIL bad_error got %b exp 1", bus0.cfg_error); end
        n_chk++; if (bus0.cfg_done !== 1'b0) begin n_fail++; $display("FAIL bad_done got %b exp 0", bus0.cfg_done); end
        n_chk++; if (bus0.fabric_reset !== 1'b1) begin n_fail++; $display("FAIL bad_fabric_reset got %b exp 1", bus0.fabric_reset); end
        s = sc0;
        for (int i = 0; i < 4; i++) send({1'b0, i[0]}, 3'b001);
        n_chk++; if (sc0 !== s) begin n_fail++; $display("FAIL error_locked got %0d shifts exp 0", sc0 - s); end
        n_chk++; if (bus0.cfg_error !== 1'b1) begin n_fail++; $display("FAIL error_sticky got %b exp 1", bus0.cfg_error); end
    endtask

    task automatic test_abort;
        pulse_prog_rst();
        for (int i = 0; i < 30; i++) send({1'b0, PAT[63-i]}, 3'b001);
        n_chk++; if (bus0.bit_count !== 7'd30) begin n_fail++; $display("FAIL abort_mid_count got %0d exp 30", bus0.bit_count); end
        pulse_prog_rst();
        n_chk++; if (bus0.bit_count !== 7'd0) begin n_fail++; $display("FAIL abort_bit_count got %0d exp 0", bus0.bit_count); end
        n_chk++; if (bus0.fabric_reset !== 1'b1) begin n_fail++; $display("FAIL abort_fabric_reset got %b exp 1", bus0.fabric_reset); end
        load0(~PAT, crc_ref(~PAT));
        n_chk++; if (bus0.cfg_done !== 1'b1) begin n_fail++; $display("FAIL abort_reload_done got %b exp 1", bus0.cfg_done); end
        n_chk++; if (cap0 !== ~PAT) begin n_fail++; $display("FAIL abort_reload_data got %h exp %h", cap0, ~PAT); end
    endtask

    task automatic test_en_gate;
        logic [63:0] d;
        int s;
        d = 64'h0123_4567_89AB_CDEF;
        pulse_prog_rst();
        s = sc0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0 && i % 6 == 0) send({1'b0, ~d[63-i]}, 3'b000);
            send({1'b0, d[63-i]}, 3'b001);
            if (i == 19) begin
                n_chk++; if (bus0.bit_count !== 7'd20) begin n_fail++; $display("FAIL gate_bit_count got %0d exp 20", bus0.bit_count); end
            end
        end
        n_chk++; if (sc0 - s !== 64) begin n_fail++; $display("FAIL gate_shift_count got %0d exp 64", sc0 - s); end
        for (int k = 0; k < 8; k++) send({1'b0, crc_ref(d) >> (7 - k)}, 3'b001);
        n_chk++; if (bus0.cfg_done !== 1'b1) begin n_fail++; $display("FAIL gate_done got %b exp 1", bus0.cfg_done); end
        n_chk++; if (cap0 !== d) begin n_fail++; $display("FAIL gate_data got %h exp %h", cap0, d); end
    endtask

    task automatic test_two_chain;
        logic [1:0] d;
        int s;
        pulse_prog_rst();
        s = sc1;
        for (int i = 0; i < 64; i++) begin
            d = i[0] ? 2'b01 : 2'b10;
            send(d, 3'b010);
            n_chk++; if (bus1.cfg_data_out !== d) begin n_fail++; $display("FAIL two_chain_data edge %0d got %b exp %b", i, bus1.cfg_data_out, d); end
        end
        n_chk++; if (sc1 - s !== 64) begin n_fail++; $display("FAIL two_chain_shifts got %0d exp 64", sc1 - s); end
        n_chk++; if (bus1.cfg_done !== 1'b1) begin n_fail++; $display("FAIL two_chain_done got %b exp 1", bus1.cfg_done); end
        n_chk++; if (bus1.bit_count !== 7'd64) begin n_fail++; $display("FAIL two_chain_count got %0d exp 64", bus1.bit_count); end
        for (int k = 0; k < 8; k++) send(2'b11, 3'b010);
        n_chk++; if (bus1.bit_count !== 7'd64) begin n_fail++; $display("FAIL two_chain_no_trailer got %0d exp 64", bus1.bit_count); end
        n_chk++; if (sc1 - s !== 64) begin n_fail++; $display("FAIL two_chain_locked got %0d exp 64", sc1 - s); end
    endtask

    task automatic test_latency;
        int n;
        bit seen;
        pulse_prog_rst();
        din = 2'b01;
        en  = 3'b100;
        cyc(4);
        pclk = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus2.cfg_shift_en;
        end
        n_chk++; if (n !== 4 || !seen) begin n_fail++; $display("FAIL latency got %0d cycles seen=%b exp 4", n, seen); end
        cyc(1);
        n_chk++; if (bus2.cfg_shift_en !== 1'b0) begin n_fail++; $display("FAIL latency_width got %b exp 0", bus2.cfg_shift_en); end
        n_chk++; if (bus2.cfg_data_out !== 1'b1) begin n_fail++; $display("FAIL latency_data got %b exp 1", bus2.cfg_data_out); end
        n_chk++; if (bus2.bit_count !== 7'd1) begin n_fail++; $display("FAIL latency_count got %0d exp 1", bus2.bit_count); end
        cyc(4);
        pclk = 1'b0;
        cyc(5);
        tail = 2'b11;
        n_chk++; if (bus2.prog_dout !== 1'b0) begin n_fail++; $display("FAIL readback_early got %b exp 0", bus2.prog_dout); end
        cyc(1);
        n_chk++; if (bus2.prog_dout !== 1'b1) begin n_fail++; $display("FAIL readback_rise got %b exp 1", bus2.prog_dout); end
        tail = 2'b10;
        cyc(1);
        n_chk++; if (bus2.prog_dout !== 1'b0) begin n_fail++; $display("FAIL readback_fall got %b exp 0", bus2.prog_dout); end
        n_chk++; if (bus1.prog_dout !== 2'b10) begin n_fail++; $display("FAIL readback_two_chain got %b exp 10", bus1.prog_dout); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        sc0 = 0; sc1 = 0; sc2 = 0; cap0 = '0;
        reset = 1'b1; pclk = 1'b0; prst = 1'b0; en = '0; din = '0; tail = '0;
        test_reset();
        test_good_load();
        test_bad_crc();
        test_abort();
        test_en_gate();
        test_two_chain();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/grain_prog_ctrl.md
Name: grain_prog_ctrl

Overview:
Clock-domain programming controller for the GrainFlex configuration chain; successor to the bare pin-level shift interface. Synchronises the external prog pins into clk, drives CHAINS parallel config shift chains, counts bits, and checks a CRC-8 trailer. Fabric reset is held until a load completes cleanly. Sits between the top-level ui_in prog pins and the fabric's config chains.

Parameters:
CHAINS, 1, number of parallel config chains loaded per prog_clk edge
CHAIN_LEN, 64, bits per chain (≥ 2)
SYNC_STAGES, 2, synchroniser depth on every prog input (≥ 2)
CRC_EN, 1, 1 = require 8-bit CRC trailer; 0 = no trailer

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
prog_clk  in  1  async external programming clock
prog_rst  in  1  async external programming reset, active high
prog_en  in  1  async shift enable
prog_din  in  CHAINS  async serial data, one bit per chain
prog_dout  out  CHAINS  registered readback of chain tails
cfg_shift_en  out  1  one-cycle shift strobe to chains
cfg_data_out  out  CHAINS  bit shifted into each chain head on cfg_shift_en
cfg_data_in  in  CHAINS  current tail bit of each chain
fabric_reset  out  1  holds fabric in reset until configured
cfg_done  out  1  load complete, CRC ok
cfg_error  out  1  CRC mismatch
bit_count  out  $clog2(CHAIN_LEN+9)  edges accepted since last clear

Behaviour:
- Reset (reset=1 at clk edge): state IDLE; fabric_reset=1; cfg_shift_en, cfg_data_out, cfg_done, cfg_error, prog_dout, bit_count, crc=0; synchronisers cleared.
- All five prog inputs pass through SYNC_STAGES flops; one extra flop on synced prog_clk for rising-edge detect. Data sampled from the same sync stage as the edge → aligned.
- cfg_shift_en asserts exactly SYNC_STAGES+1 cycles after the first clk edge that samples prog_clk high; width 1 cycle. Host keeps prog_clk high and low ≥ SYNC_STAGES+1 clk cycles each.
- States: IDLE, LOAD, TRAILER, RUN, ERROR.
- Synced prog_rst=1 in any state: next state IDLE, bit_count=0, crc=0, cfg_done=cfg_error=0, fabric_reset=1. Overrides a coincident edge (no shift).
- Edge accepted only when synced prog_en=1; edges with prog_en=0 ignored entirely (no shift, no count).
- IDLE: accepted edge → cfg_shift_en pulse, cfg_data_out=sampled prog_din, bit_count=1, crc updated, → LOAD.
- LOAD: each accepted edge shifts and increments bit_count. Edge making bit_count==CHAIN_LEN → TRAILER if CRC_EN else RUN.
- CRC-8: poly 0x07, init 0x00, non-reflected; per edge absorbs prog_din[0], prog_din[1], … prog_din[CHAINS-1] in that order (unrolled combinationally).
- TRAILER: accepted edges do not shift chains; prog_din[0] shifted MSB-first into trailer register, bit_count increments. On 8th trailer bit: trailer==crc → RUN; else → ERROR.
- RUN: cfg_done=1, fabric_reset=0 (next cycle after transition). Further edges ignored; chains locked.
- ERROR: cfg_error=1, fabric_reset=1, edges ignored. Exit only via prog_rst or reset.
- prog_dout registered from cfg_data_in every clk cycle in all states (readback; 1-cycle latency).
- bit_count saturates; never wraps.

Decomposition:
- Package grain_prog_pkg: state enum, CRC8_POLY=8'h07, CRC8_INIT=8'h00, crc8_step function (1 bit).
- Sub-module grain_sync_edge: SYNC_STAGES-deep synchroniser bank (width parameter) plus rising-edge detect on bit 0; instanced once for {prog_din, prog_en, prog_rst, prog_clk}.

Test Plan:
- CHAINS=1, CHAIN_LEN=64: pulse prog_rst, shift 64 bits 0xA5 pattern + correct CRC → 64 cfg_shift_en pulses, cfg_done=1, fabric_reset=0, bit_count=72.
- Same load, trailer with bit 0 flipped → cfg_error=1, cfg_done=0, fabric_reset=1; further edges produce no cfg_shift_en.
- Assert prog_rst after 30 bits → IDLE, bit_count=0, fabric_reset=1; fresh full load then succeeds.
- 10 prog_clk edges with prog_en=0 interleaved in a load → ignored; bit_count and CRC unchanged, load still passes.
- CHAINS=2, CRC_EN=0: 64 edges with din=2'b10 alternating 2'b01 → cfg_data_out matches per edge, RUN after 64th edge, no trailer accepted.
- Latency: SYNC_STAGES=3, single edge → cfg_shift_en exactly 4 cycles after sampling; cfg_data_in toggle → prog_dout follows 1 cycle later.
